// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : Four-channel switch conditioner. The raw switch pins are
//            synchronised with a two-flop chain and then bounce-filtered. Each
//            channel accepts a new level only after it has held for
//            DEBOUNCE_CYCLES consecutive synchronised cycles. The outputs feed
//            the full-adder/full-subtractor operand, carry and mode inputs.
// Ports    : CLK      - system clock, rising edge
//            RST      - synchronous active-high reset
//            SW_RAW   - raw asynchronous switch pins (bit0 -> SW1 .. bit3 -> SW4)
//            SW1..SW4 - debounced, registered switch levels
//            SW_RISE  - one-cycle pulse per channel on a debounced 0->1 change
//            SW_FALL  - one-cycle pulse per channel on a debounced 1->0 change
//            SETTLED  - high while every channel is idle (no qualification
//                       in progress)
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SW_RAW,
  output logic       SW1,
  output logic       SW2,
  output logic       SW3,
  output logic       SW4,
  output logic [3:0] SW_RISE,
  output logic [3:0] SW_FALL,
  output logic       SETTLED
);

  localparam int NUM_CH = 4;

  // Terminal count: the qualifying sample that sees cnt at this value
  // commits the new level. The compare happens before any increment, so
  // cnt never has to hold DEBOUNCE_CYCLES itself and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  // Two-flop synchroniser. Only sync2 is allowed to reach the filters.
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW_RAW;
      sync2 <= sync1;
    end
  end

  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] idle;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t           state;
      state_t           state_next;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_next;
      logic             lvl;
      logic             lvl_next;
      logic             rise_q;
      logic             rise_next;
      logic             fall_q;
      logic             fall_next;

      always_ff @(posedge CLK) begin
        if (RST) begin
          state  <= STABLE;
          cnt    <= '0;
          lvl    <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          state  <= state_next;
          cnt    <= cnt_next;
          lvl    <= lvl_next;
          rise_q <= rise_next;
          fall_q <= fall_next;
        end
      end

      always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lvl_next   = lvl;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
          STABLE: begin
            if (sync2[g] != lvl) begin
              // This sample is the first qualifying cycle.
              state_next = COUNT;
              cnt_next   = CNT_W'(1);
            end else begin
              cnt_next = '0;
            end
          end
          COUNT: begin
            if (sync2[g] == lvl) begin
              // Bounce back to the old level: discard all progress.
              state_next = STABLE;
              cnt_next   = '0;
            end else if (cnt == CNT_TERM) begin
              state_next = STABLE;
              cnt_next   = '0;
              lvl_next   = sync2[g];
              rise_next  = sync2[g];
              fall_next  = ~sync2[g];
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end
          default: begin
            state_next = STABLE;
            cnt_next   = '0;
          end
        endcase
      end

      assign level[g] = lvl;
      assign rise[g]  = rise_q;
      assign fall[g]  = fall_q;
      assign idle[g]  = (state == STABLE);
    end
  endgenerate

  assign SW1     = level[0];
  assign SW2     = level[1];
  assign SW3     = level[2];
  assign SW4     = level[3];
  assign SW_RISE = rise;
  assign SW_FALL = fall;
  assign SETTLED = &idle;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce
// Purpose  : Self-checking bench for sw_debounce with DEBOUNCE_CYCLES = 4.
//            Every cycle, a run-length reference model predicts the outputs,
//            which are queued at drive time and compared after the edge.
//            Directed latency/pulse checks cover the listed scenarios.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] SW_RAW = 4'b0000;
  logic       SW1, SW2, SW3, SW4;
  logic [3:0] SW_RISE, SW_FALL;
  logic       SETTLED;

  always #5 CLK = ~CLK;

  sw_debounce #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SW_RAW  (SW_RAW),
    .SW1     (SW1),
    .SW2     (SW2),
    .SW3     (SW3),
    .SW4     (SW4),
    .SW_RISE (SW_RISE),
    .SW_FALL (SW_FALL),
    .SETTLED (SETTLED)
  );

  typedef struct packed {
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       settled;
  } obs_t;

  obs_t  exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  string scen     = "reset";

  // Reference model: synchroniser pipeline plus, per channel, the length of
  // the current run of samples that disagree with the accepted level.
  logic [3:0] m_s1 = '0;
  logic [3:0] m_s2 = '0;
  logic [3:0] m_out = '0;
  int         run[4] = '{0, 0, 0, 0};

  function automatic obs_t observe();
    obs_t o;
    o.sw      = {SW4, SW3, SW2, SW1};
    o.rise    = SW_RISE;
    o.fall    = SW_FALL;
    o.settled = SETTLED;
    return o;
  endfunction

  function automatic logic [1:0] ld_of(input logic [3:0] s);
    logic a, b, c, m;
    a = s[0]; b = s[1]; c = s[2]; m = s[3];
    if (m) return {(~a & b) | (~(a ^ b) & c), a ^ b ^ c};
    else   return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", scen, tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the predicted post-edge outputs, then
  // compare on the following falling edge.
  task automatic step(input logic rst, input logic [3:0] raw);
    obs_t e;
    obs_t got;
    RST    = rst;
    SW_RAW = raw;
    e = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_out[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_out[i] = m_s2[i];
            if (m_s2[i]) e.rise[i] = 1'b1;
            else         e.fall[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    e.sw      = m_out;
    e.settled = (run[0] == 0) && (run[1] == 0) && (run[2] == 0) && (run[3] == 0);
    exp_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'(0), 32'(1));
    end else begin
      got = observe();
      check("cycle", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    int first;
    int cnt_a;
    int cnt_b;
    int cnt_c;
    logic [3:0] seen;
    logic [3:0] prev_sw;
    logic [1:0] ld_prev;
    logic [1:0] ld_now;

    // ---- reset ----
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    check("reset_sw", 32'({SW4, SW3, SW2, SW1}), 32'(0));
    check("reset_pulses", 32'({SW_RISE, SW_FALL}), 32'(0));
    check("reset_settled", 32'(SETTLED), 32'(1));

    // ---- clean rise ----
    scen = "clean_rise";
    step(1'b0, 4'b0001);
    first = -1; cnt_a = 0; cnt_b = 0; cnt_c = 0; seen = '0;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'b0001);
      if (SW1 && first < 0) first = e;
      if (SW_RISE != 4'b0000) begin cnt_a++; seen = SW_RISE; end
      if (!SETTLED) cnt_b++;
      if ({SW4, SW3, SW2} != 3'b000) cnt_c++;
    end
    check("sw1_latency", 32'(first), 32'(5));
    check("rise_pulses", 32'(cnt_a), 32'(1));
    check("rise_value", 32'(seen), 32'(4'b0001));
    check("unsettled_cycles", 32'(cnt_b), 32'(3));
    check("others_quiet", 32'(cnt_c), 32'(0));

    // ---- glitch reject on bit2 ----
    scen = "glitch";
    cnt_a = 0; cnt_b = 0;
    for (int e = 0; e < 8; e++) begin
      step(1'b0, (e < 2) ? 4'b0101 : 4'b0001);
      if (SW3) cnt_a++;
      if ((SW_RISE | SW_FALL) != 4'b0000) cnt_b++;
    end
    check("sw3_unchanged", 32'(cnt_a), 32'(0));
    check("no_pulses", 32'(cnt_b), 32'(0));
    check("settled_again", 32'(SETTLED), 32'(1));

    // ---- bounce then settle on bit3 ----
    scen = "bounce";
    cnt_a = 0;
    step(1'b0, 4'b1001);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b1001);
    step(1'b0, 4'b0001);
    if (SW4) cnt_a = 99;
    step(1'b0, 4'b1001);  // final capture
    first = -1;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'b1001);
      if (SW4 && first < 0) first = e;
      if (SW_RISE[3]) cnt_a++;
    end
    check("sw4_latency", 32'(first), 32'(5));
    check("sw4_rise_pulses", 32'(cnt_a), 32'(1));
    cnt_b = 0; seen = '0;
    for (int e = 0; e < 8; e++) begin
      step(1'b0, 4'b0001);
      if (SW_FALL != 4'b0000) begin cnt_b++; seen = SW_FALL; end
    end
    check("fall_pulses", 32'(cnt_b), 32'(1));
    check("fall_value", 32'(seen), 32'(4'b1000));
    check("sw4_low", 32'(SW4), 32'(0));

    // ---- parallel channels ----
    scen = "parallel";
    for (int e = 0; e < 8; e++) step(1'b0, 4'b0000);
    check("all_low", 32'({SW4, SW3, SW2, SW1}), 32'(0));
    step(1'b0, 4'b1111);
    first = -1; cnt_a = 0; cnt_b = 0;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'b1111);
      if ({SW4, SW3, SW2, SW1} != 4'b0000 && first < 0) begin
        first = e;
        check("same_edge", 32'({SW4, SW3, SW2, SW1}), 32'(4'b1111));
      end
      if (SW_RISE == 4'b1111) cnt_a++;
      if (SW_RISE != 4'b0000) cnt_b++;
    end
    check("parallel_latency", 32'(first), 32'(5));
    check("rise_all_once", 32'(cnt_a), 32'(1));
    check("rise_any_once", 32'(cnt_b), 32'(1));

    // ---- reset mid-count ----
    scen = "reset_mid";
    for (int e = 0; e < 8; e++) step(1'b0, 4'b0000);
    cnt_a = 0;
    for (int e = 0; e < 3; e++) begin
      step(1'b0, 4'b0001);
      if (SW1) cnt_a++;
    end
    step(1'b1, 4'b0001);  // reset at edge 3 of qualification
    if (SW1) cnt_a++;
    check("sw1_never_high", 32'(cnt_a), 32'(0));
    check("settled_after_reset", 32'(SETTLED), 32'(1));
    step(1'b0, 4'b0001);  // first post-reset capture
    first = -1;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'b0001);
      if (SW1 && first < 0) first = e;
    end
    check("requalify_latency", 32'(first), 32'(5));

    // ---- system sweep ----
    scen = "sweep";
    prev_sw = {SW4, SW3, SW2, SW1};
    for (int code = 0; code < 16; code++) begin
      ld_prev = ld_of({SW4, SW3, SW2, SW1});
      cnt_a = 0;
      for (int t = 0; t < 20; t++) begin
        step(1'b0, 4'(code));
        ld_now = ld_of({SW4, SW3, SW2, SW1});
        if (ld_now != ld_prev) cnt_a++;
        ld_prev = ld_now;
        if (t == 4) check("hold_prev", 32'({SW4, SW3, SW2, SW1}), 32'(prev_sw));
        if (t == 5) check("code_out", 32'({SW4, SW3, SW2, SW1}), 32'(code));
      end
      check("ld_single_change", 32'(cnt_a > 1), 32'(0));
      prev_sw = 4'(code);
    end

    scen = "end";
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
